conv2_window_buf: RTL and testbench
===================================

Name: conv2_window_buf

Overview:
- Streaming sliding-window generator feeding the 2nd convolution layer of the MNIST CNN.
- Accepts the three pooled layer-1 feature maps (12x12 each), one pixel per channel per accepted cycle, in raster order.
- Emits every complete 5x5 window for all three channels in parallel, with a one-cycle valid_out_buf strobe, to the conv2 channel-sum calculators.
- Produces the 8x8 = 64 windows per frame that conv2 consumes.

Parameters:
- IMG_W, 12, input map width and height in pixels (square)
- K, 5, kernel edge; window has K*K = 25 elements
- DW, 12, signed data width per pixel

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- valid_in  in  1  pixel strobe; data_in1..3 are sampled when high
- data_in1  in  DW  channel-1 pixel, signed
- data_in2  in  DW  channel-2 pixel, signed
- data_in3  in  DW  channel-3 pixel, signed
- data_out1  out  K*K*DW (300)  channel-1 window; element k occupies bits [DW*k+DW-1 : DW*k]
- data_out2  out  300  channel-2 window, same packing
- data_out3  out  300  channel-3 window, same packing
- valid_out_buf  out  1  one-cycle strobe; windows are valid in that cycle
- frame_done  out  1  one-cycle strobe coincident with the 64th window of a frame

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high.
- Reset values:
  - all outputs 0; row/col counters 0
  - line-buffer contents 0; window counter 0
- Storage: per channel, a shift chain of (K-1)*IMG_W + K = 53 entries, DW bits each.
  - Advances only on cycles with valid_in=1; holds otherwise.
  - Gaps of any length between pixels are legal.
- Position counters: col 0..IMG_W-1 and row 0..IMG_W-1 give the position of the accepted pixel.
  - col wraps to 0 and row increments at col=IMG_W-1.
  - At row=IMG_W-1, col=IMG_W-1 both wrap to 0. The next pixel starts a new frame with no idle cycle required.
- Window complete: the accepted pixel has row>=K-1 and col>=K-1.
- Output latency: window outputs and valid_out_buf are registered.
  - valid_out_buf is high in the cycle after the completing pixel is accepted.
  - valid_out_buf is low in all other cycles, so it is never held for two cycles on one pixel.
  - data_out* hold their value until the next window is produced.
- Window element ordering: element k = r*K + c.
  - r=0 is the top (oldest) row; c=0 is the leftmost column.
  - Element 24 is the pixel just accepted.
  - Element (r,c) equals input pixel (row-4+r, col-4+c).
- No window is ever emitted from pixels in cols 0..3 or rows 0..3. Windows never straddle a row wrap.
- Window count per frame is exactly 64. frame_done pulses with valid_out_buf for window 63, i.e. the pixel at (11,11).
- Data is passed through bit-exact: no arithmetic, saturation or sign change.
- Reset mid-frame clears counters and buffers. The next valid pixel is treated as (0,0) of a new frame. Any pending output strobe is suppressed.
- No backpressure: the consumer must accept one window per strobe. Strobes can occur on consecutive cycles.

Decomposition:
- Shared package cnn_pkg holds:
  - IMG_W2 = 12, K2 = 5, DW_L1 = 12
  - WIN_ELEMS = 25, WINDOWS_PER_FRAME2 = 64
- Sub-module conv2_line_buf is natural:
  - contains a single-channel 53-entry shift chain plus 25-element packed tap output
  - is instantiated three times, sharing one position counter and control block in conv2_window_buf

Test Plan:
- Ramp stimulus:
  - Stimulus: one frame, back-to-back valid_in. ch1 = row*12+col; ch2 = ch1+200; ch3 = -(ch1).
  - First strobe comes one cycle after pixel 52 at (4,4).
  - data_out1 element 0 = 0, element 12 = 26, element 24 = 52.
  - ch2 element 24 = 252; ch3 element 24 = 0xFCC (-52).
- Full-frame count:
  - Exactly 64 valid_out_buf pulses.
  - No pulse for any pixel with col<4 or row<4.
  - frame_done is a single pulse with the window whose element 24 = 143 and element 0 = 91.
- Gapped input:
  - Same ramp with valid_in randomly low ~50%.
  - Windows are identical to the back-to-back run, in the same order.
  - Outputs hold between strobes.
- Two back-to-back frames:
  - Second frame ramp offset +1000.
  - Its first window has element 0 = 1000 and element 24 = 1052.
  - No window mixes frame-1 and frame-2 pixels.
- Mid-frame reset:
  - Assert rst for one cycle after pixel 70, then restart the ramp.
  - Outputs are 0 during reset, and there is no strobe from pre-reset pixels.
  - First post-reset strobe follows the new pixel 52 with element 24 = 52.

Source files
------------

// File: rtl/conv2_window_buf_pkg.sv
// Shared constants for the conv2 input stage of the MNIST CNN.
package cnn_pkg;

    localparam int IMG_W2             = 12;
    localparam int K2                 = 5;
    localparam int DW_L1              = 12;
    localparam int WIN_ELEMS          = K2 * K2;
    localparam int WINDOWS_PER_FRAME2 = (IMG_W2 - K2 + 1) * (IMG_W2 - K2 + 1);
    localparam int CHAIN_LEN2         = (K2 - 1) * IMG_W2 + K2;

    // Distance (in accepted pixels) from the newest pixel back to window tap (r,c).
    function automatic int tap_dist(input int img_w, input int k, input int r, input int c);
        return (k - 1 - r) * img_w + (k - 1 - c);
    endfunction

endpackage

// File: rtl/conv2_window_buf_if.sv
// Pixel stream in, three-channel window stream out.
interface conv2_window_buf_if
    import cnn_pkg::*;
#(
    parameter int K  = K2,
    parameter int DW = DW_L1
);

    logic                valid_in;
    logic [DW-1:0]       data_in1;
    logic [DW-1:0]       data_in2;
    logic [DW-1:0]       data_in3;
    logic [K*K*DW-1:0]   data_out1;
    logic [K*K*DW-1:0]   data_out2;
    logic [K*K*DW-1:0]   data_out3;
    logic                valid_out_buf;
    logic                frame_done;

    modport master (
        output valid_in, data_in1, data_in2, data_in3,
        input  data_out1, data_out2, data_out3, valid_out_buf, frame_done
    );

    modport slave (
        input  valid_in, data_in1, data_in2, data_in3,
        output data_out1, data_out2, data_out3, valid_out_buf, frame_done
    );

endinterface

// File: rtl/conv2_window_buf_line_buf.sv
// Single-channel line buffer: shift chain spanning K-1 full rows plus K pixels,
// with a registered K*K window tapped from it.
module conv2_line_buf
    import cnn_pkg::*;
#(
    parameter int IMG_W = IMG_W2,
    parameter int K     = K2,
    parameter int DW    = DW_L1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                load,
    input  logic [DW-1:0]       din,
    output logic [K*K*DW-1:0]   win
);

    // The live input pixel is the newest chain position, so only the older
    // (K-1)*IMG_W + K - 1 positions need storage.
    localparam int STORE_LEN = (K - 1) * IMG_W + K - 1;

    logic [DW-1:0]       chain_r [STORE_LEN];
    logic [K*K*DW-1:0]   taps_s;
    logic [K*K*DW-1:0]   win_r;

    // Shift chain advances only on accepted pixels.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STORE_LEN; i++) begin
                chain_r[i] <= '0;
            end
        end else if (en) begin
            chain_r[0] <= din;
            for (int i = 1; i < STORE_LEN; i++) begin
                chain_r[i] <= chain_r[i-1];
            end
        end
    end

    for (genvar r = 0; r < K; r++) begin : g_row
        for (genvar c = 0; c < K; c++) begin : g_col
            localparam int DIST = tap_dist(IMG_W, K, r, c);
            if (DIST == 0) begin : g_live
                assign taps_s[(r*K+c)*DW +: DW] = din;
            end else begin : g_stored
                assign taps_s[(r*K+c)*DW +: DW] = chain_r[DIST-1];
            end
        end
    end

    // Window register captures the taps when the accepted pixel completes a window.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_r <= '0;
        end else if (load) begin
            win_r <= taps_s;
        end
    end

    assign win = win_r;

endmodule

// File: rtl/conv2_window_buf.sv
// Three-channel 5x5 sliding-window generator for the conv2 layer.
module conv2_window_buf
    import cnn_pkg::*;
#(
    parameter int IMG_W = IMG_W2,
    parameter int K     = K2,
    parameter int DW    = DW_L1
) (
    input  logic               clk,
    input  logic               rst,
    conv2_window_buf_if.slave  bus
);

    localparam int CW  = $clog2(IMG_W);
    localparam int WPF = (IMG_W - K + 1) * (IMG_W - K + 1);
    localparam int WCW = $clog2(WPF);

    localparam logic [CW-1:0]  POS_LAST  = CW'(IMG_W - 1);
    localparam logic [CW-1:0]  WIN_FIRST = CW'(K - 1);
    localparam logic [WCW-1:0] WIN_LAST  = WCW'(WPF - 1);

    logic [CW-1:0]  col_r;
    logic [CW-1:0]  row_r;
    logic [WCW-1:0] win_cnt_r;
    logic           win_ok_s;
    logic           last_win_s;
    logic           valid_out_buf_r;
    logic           frame_done_r;

    // Raster position of the pixel being accepted; wraps to a new frame with no gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_r <= '0;
            row_r <= '0;
        end else if (bus.valid_in) begin
            if (col_r == POS_LAST) begin
                col_r <= '0;
                if (row_r == POS_LAST) begin
                    row_r <= '0;
                end else begin
                    row_r <= row_r + CW'(1);
                end
            end else begin
                col_r <= col_r + CW'(1);
            end
        end
    end

    // A window completes when the accepted pixel is at least K-1 rows and columns in.
    always_comb begin
        win_ok_s   = 1'b0;
        last_win_s = 1'b0;
        if (bus.valid_in && (row_r >= WIN_FIRST) && (col_r >= WIN_FIRST)) begin
            win_ok_s   = 1'b1;
            last_win_s = (win_cnt_r == WIN_LAST);
        end else begin
            win_ok_s   = 1'b0;
            last_win_s = 1'b0;
        end
    end

    // Windows emitted so far in the current frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt_r <= '0;
        end else if (win_ok_s) begin
            if (last_win_s) begin
                win_cnt_r <= '0;
            end else begin
                win_cnt_r <= win_cnt_r + WCW'(1);
            end
        end
    end

    // Registered strobes, aligned with the window registers in the line buffers.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out_buf_r <= 1'b0;
            frame_done_r    <= 1'b0;
        end else begin
            valid_out_buf_r <= win_ok_s;
            frame_done_r    <= last_win_s;
        end
    end

    assign bus.valid_out_buf = valid_out_buf_r;
    assign bus.frame_done    = frame_done_r;

    conv2_line_buf #(.IMG_W(IMG_W), .K(K), .DW(DW)) u_lb1 (
        .clk  (clk),
        .rst  (rst),
        .en   (bus.valid_in),
        .load (win_ok_s),
        .din  (bus.data_in1),
        .win  (bus.data_out1)
    );

    conv2_line_buf #(.IMG_W(IMG_W), .K(K), .DW(DW)) u_lb2 (
        .clk  (clk),
        .rst  (rst),
        .en   (bus.valid_in),
        .load (win_ok_s),
        .din  (bus.data_in2),
        .win  (bus.data_out2)
    );

    conv2_line_buf #(.IMG_W(IMG_W), .K(K), .DW(DW)) u_lb3 (
        .clk  (clk),
        .rst  (rst),
        .en   (bus.valid_in),
        .load (win_ok_s),
        .din  (bus.data_in3),
        .win  (bus.data_out3)
    );

endmodule

// File: tb/tb_conv2_window_buf.sv
// Directed bench for conv2_window_buf with an image-model scoreboard.
module tb_conv2_window_buf;
    import cnn_pkg::*;

    localparam int W = 300;

    typedef struct {
        logic [W-1:0] w1;
        logic [W-1:0] w2;
        logic [W-1:0] w3;
        logic         fd;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    conv2_window_buf_if ifc ();

    conv2_window_buf dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    exp_t         sb_q[$];
    logic [11:0]  img1 [144];
    logic [11:0]  img2 [144];
    logic [11:0]  img3 [144];
    int           tb_row, tb_col;
    int           n_pass, n_total, n_fail;
    int           strobes;
    logic [W-1:0] held1, held2, held3;
    logic [W-1:0] first1, first2, first3, last1;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [11:0] el(input logic [W-1:0] w, input int k);
        return w[k*12 +: 12];
    endfunction

    // Drive one cycle, update the image model, then check outputs on the falling edge.
    task automatic px(input logic v, input logic [11:0] d1, input logic [11:0] d2, input logic [11:0] d3);
        exp_t e;
        logic strobe;
        ifc.valid_in = v;
        ifc.data_in1 = d1;
        ifc.data_in2 = d2;
        ifc.data_in3 = d3;
        strobe = 1'b0;
        if (v) begin
            img1[tb_row*12+tb_col] = d1;
            img2[tb_row*12+tb_col] = d2;
            img3[tb_row*12+tb_col] = d3;
            if (tb_row >= 4 && tb_col >= 4) begin
                for (int r = 0; r < 5; r++) begin
                    for (int c = 0; c < 5; c++) begin
                        e.w1[(r*5+c)*12 +: 12] = img1[(tb_row-4+r)*12 + tb_col-4+c];
                        e.w2[(r*5+c)*12 +: 12] = img2[(tb_row-4+r)*12 + tb_col-4+c];
                        e.w3[(r*5+c)*12 +: 12] = img3[(tb_row-4+r)*12 + tb_col-4+c];
                    end
                end
                e.fd = (tb_row == 11 && tb_col == 11);
                sb_q.push_back(e);
                strobe = 1'b1;
            end
            if (tb_col == 11) begin
                tb_col = 0;
                tb_row = (tb_row == 11) ? 0 : tb_row + 1;
            end else begin
                tb_col++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("valid_out_buf", ifc.valid_out_buf, strobe);
        if (strobe) begin
            e = sb_q.pop_front();
            chk("frame_done", ifc.frame_done, e.fd);
            chk("win_ch1", ifc.data_out1, e.w1);
            chk("win_ch2", ifc.data_out2, e.w2);
            chk("win_ch3", ifc.data_out3, e.w3);
            held1 = e.w1;
            held2 = e.w2;
            held3 = e.w3;
            if (strobes == 0) begin
                first1 = ifc.data_out1;
                first2 = ifc.data_out2;
                first3 = ifc.data_out3;
            end
            if (e.fd) last1 = ifc.data_out1;
            strobes++;
        end else begin
            chk("frame_done_idle", ifc.frame_done, 1'b0);
            chk("hold_ch1", ifc.data_out1, held1);
            chk("hold_ch2", ifc.data_out2, held2);
            chk("hold_ch3", ifc.data_out3, held3);
        end
    endtask

    // Ramp of n pixels starting at offset off, optionally with idle gaps.
    task automatic frame(input int off, input bit gaps, input int n);
        int v;
        strobes = 0;
        for (int p = 0; p < n; p++) begin
            if (gaps) begin
                repeat ($urandom_range(2, 0)) px(1'b0, 12'($urandom), 12'($urandom), 12'($urandom));
            end
            v = off + p;
            px(1'b1, 12'(v), 12'(v + 200), 12'(-v));
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, ifc.valid_out_buf, 1'b0);
        chk({tag, "_fdone"}, ifc.frame_done, 1'b0);
        chk({tag, "_ch1"}, ifc.data_out1, '0);
        chk({tag, "_ch2"}, ifc.data_out2, '0);
        chk({tag, "_ch3"}, ifc.data_out3, '0);
    endtask

    initial begin
        n_pass = 0; n_total = 0; n_fail = 0; strobes = 0;
        tb_row = 0; tb_col = 0;
        held1 = '0; held2 = '0; held3 = '0;
        first1 = '0; first2 = '0; first3 = '0; last1 = '0;
        rst = 1'b1;
        ifc.valid_in = 1'b0;
        ifc.data_in1 = 12'h000;
        ifc.data_in2 = 12'h000;
        ifc.data_in3 = 12'h000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Back-to-back ramp frame
        frame(0, 1'b0, 144);
        chk("ramp_count", 32'(strobes), 32'd64);
        chk("ramp_e0", el(first1, 0), 12'd0);
        chk("ramp_e12", el(first1, 12), 12'd26);
        chk("ramp_e24", el(first1, 24), 12'd52);
        chk("ramp_ch2_e24", el(first2, 24), 12'd252);
        chk("ramp_ch3_e24", el(first3, 24), 12'hFCC);
        chk("last_e24", el(last1, 24), 12'd143);
        chk("last_e0", el(last1, 0), 12'd91);

        // Gapped ramp frame
        frame(0, 1'b1, 144);
        chk("gap_count", 32'(strobes), 32'd64);
        chk("gap_e24", el(first1, 24), 12'd52);

        // Two back-to-back frames, second offset by 1000
        frame(0, 1'b0, 144);
        chk("f1_count", 32'(strobes), 32'd64);
        frame(1000, 1'b0, 144);
        chk("f2_count", 32'(strobes), 32'd64);
        chk("f2_e0", el(first1, 0), 12'd1000);
        chk("f2_e24", el(first1, 24), 12'd1052);
        chk("f2_last_e24", el(last1, 24), 12'd1143);

        // Mid-frame reset after pixel 70, with a pixel presented during reset
        frame(0, 1'b0, 71);
        rst = 1'b1;
        ifc.valid_in = 1'b1;
        ifc.data_in1 = 12'h7AB;
        ifc.data_in2 = 12'h3CD;
        ifc.data_in3 = 12'h5EF;
        @(posedge clk);
        @(negedge clk);
        check_zero("midrst");
        rst = 1'b0;
        ifc.valid_in = 1'b0;
        tb_row = 0;
        tb_col = 0;
        held1 = '0; held2 = '0; held3 = '0;
        sb_q.delete();
        px(1'b0, 12'h111, 12'h222, 12'h333);
        frame(0, 1'b0, 144);
        chk("post_rst_count", 32'(strobes), 32'd64);
        chk("post_rst_e24", el(first1, 24), 12'd52);
        chk("post_rst_e0", el(first1, 0), 12'd0);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
